// File: rtl/event_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : event_counter_pkg
// Purpose  : Shared constants and helpers for the multi-channel debounced
//            event counter: debounce timer sizing, default debounce lengths
//            for hardware and simulation builds, and count-bus slice indexing.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package event_counter_pkg;

    // Default debounce lengths: board build vs. fast simulation build.
    localparam int DB_CYCLES_HW  = 100000;
    localparam int DB_CYCLES_SIM = 4;

    // Width of the debounce timer. The timer only ever holds 0..cycles-1,
    // so clog2(cycles) bits suffice; never narrower than one bit.
    function automatic int timer_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

    // Low bit index of channel ch inside a packed bus of width-bit fields.
    function automatic int slice_lo(input int ch, input int width);
        return ch * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module   : debounce_channel
// Purpose  : One input path: 2-flop synchroniser, debounce timer, accepted
//            stable level and a registered one-cycle event pulse.
// Ports    : clock_i   - system clock (rising edge)
//            reset_ni  - asynchronous active-low reset
//            raw_i     - raw, unsynchronised switch level
//            stable_o  - accepted, debounced level
//            pulse_o   - registered one-cycle pulse on a counting edge
//            event_o   - combinational strobe: the next rising edge is a
//                        counting edge (lets the counter update on the same
//                        edge that stable_o changes)
// Config   : COUNT_BOTH_EDGES_EN - when defined, 1->0 acceptances also count
// Revision : 1.0 - initial release
// ============================================================================
module debounce_channel
    import event_counter_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_HW
) (
    input  logic clock_i,
    input  logic reset_ni,
    input  logic raw_i,
    output logic stable_o,
    output logic pulse_o,
    output logic event_o
);

    localparam int               TMR_W    = timer_width(DB_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic             pulse_q;
    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timer_d;
    logic             accept;
    logic             event_w;

    // Timer runs only while the synchronised level disagrees with the
    // accepted level; any agreement snaps it back to zero.
    always_comb begin
        timer_d  = '0;
        stable_d = stable_q;
        accept   = 1'b0;
        if (sync2_q != stable_q) begin
            if (timer_q == TMR_LAST) begin
                accept   = 1'b1;
                stable_d = sync2_q;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

`ifdef COUNT_BOTH_EDGES_EN
    assign event_w = accept;
`else
    // Only a newly accepted high level is an event.
    assign event_w = accept & sync2_q;
`endif

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            timer_q  <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            timer_q  <= timer_d;
            pulse_q  <= event_w;
        end
    end

    assign stable_o = stable_q;
    assign pulse_o  = pulse_q;
    assign event_o  = event_w;

endmodule
`default_nettype wire

// File: rtl/multi_channel_event_counter.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_event_counter
// Purpose  : Debounces NUM_CH raw switch inputs and keeps one up/down event
//            counter per channel, with wrap or saturate arithmetic and a
//            sticky overflow flag. Counts are exported as a packed bus.
// Ports    : clock       - system clock (rising edge)
//            reset_n     - asynchronous active-low reset
//            sw_in       - raw switch levels            [NUM_CH]
//            dir         - per-channel direction, 1=up  [NUM_CH]
//            clear       - per-channel synchronous clear [NUM_CH]
//            debounced   - accepted stable levels       [NUM_CH]
//            event_pulse - one-cycle event pulses       [NUM_CH]
//            count_bus   - packed counts, ch k at [k*CNT_W +: CNT_W]
//            overflow    - sticky wrap/clamp flags      [NUM_CH]
// Config   : COUNT_BOTH_EDGES_EN - count both edges of the debounced level
// Revision : 1.0 - initial release
// ============================================================================
module multi_channel_event_counter
    import event_counter_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 8,
    parameter int DB_CYCLES = DB_CYCLES_HW,
    parameter int SATURATE  = 0
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       sw_in,
    input  logic [NUM_CH-1:0]       dir,
    input  logic [NUM_CH-1:0]       clear,
    output logic [NUM_CH-1:0]       debounced,
    output logic [NUM_CH-1:0]       event_pulse,
    output logic [NUM_CH*CNT_W-1:0] count_bus,
    output logic [NUM_CH-1:0]       overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MIN = '0;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic             event_w;
        logic [CNT_W-1:0] count_q;
        logic [CNT_W-1:0] count_d;
        logic             ovf_q;
        logic             ovf_d;

        debounce_channel #(
            .DB_CYCLES (DB_CYCLES)
        ) u_debounce (
            .clock_i  (clock),
            .reset_ni (reset_n),
            .raw_i    (sw_in[k]),
            .stable_o (debounced[k]),
            .pulse_o  (event_pulse[k]),
            .event_o  (event_w)
        );

        // Clear wins over a coincident event; the pulse itself is unaffected.
        always_comb begin
            count_d = count_q;
            ovf_d   = ovf_q;
            if (clear[k]) begin
                count_d = '0;
                ovf_d   = 1'b0;
            end else if (event_w) begin
                if (dir[k]) begin
                    if (count_q == CNT_MAX) begin
                        ovf_d   = 1'b1;
                        count_d = (SATURATE != 0) ? CNT_MAX : CNT_MIN;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end else begin
                    if (count_q == CNT_MIN) begin
                        ovf_d   = 1'b1;
                        count_d = (SATURATE != 0) ? CNT_MIN : CNT_MAX;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                count_q <= '0;
                ovf_q   <= 1'b0;
            end else begin
                count_q <= count_d;
                ovf_q   <= ovf_d;
            end
        end

        assign count_bus[slice_lo(k, CNT_W) +: CNT_W] = count_q;
        assign overflow[k]                            = ovf_q;
    end

endmodule
`default_nettype wire

// File: doc/multi_channel_event_counter.md
Name: multi_channel_event_counter

Overview:
Parametrised successor to the single-switch debounced counter. Debounces NUM_CH raw switch/button inputs synchronously (no derived clocks, no counting on data edges) and keeps one up/down event counter per channel. Counts are exported as a packed bus to the seven-segment display FSM. Sits between board switches/buttons and the display driver.

Parameters:
NUM_CH, 4, number of independent input channels (1..16)
CNT_W, 8, width of each channel counter
DB_CYCLES, 100000, clock cycles an input must be stable before it is accepted (>=2)
SATURATE, 0, 0 = counters wrap modulo 2^CNT_W; 1 = counters clamp at 0 / 2^CNT_W-1

Ports:
clock  input  1  system clock, all logic on its rising edge
reset_n  input  1  asynchronous active-low reset
sw_in  input  NUM_CH  raw, unsynchronised switch/button levels
dir  input  NUM_CH  per-channel direction, 1 = up, 0 = down; sampled on the counting edge
clear  input  NUM_CH  per-channel synchronous clear of count and overflow flag
debounced  output  NUM_CH  accepted, stable level of each input
event_pulse  output  NUM_CH  one-cycle pulse per counted event
count_bus  output  NUM_CH*CNT_W  packed counts, channel k at [k*CNT_W +: CNT_W]
overflow  output  NUM_CH  sticky flag: a wrap or a clamp occurred

Behaviour:
- Clock is named clock; reset is reset_n, asynchronous, active-low. These are fixed.
- Reset: all outputs are 0. Synchroniser flops, stable levels and debounce timers are also 0.
- Per channel, the input path is a 2-flop synchroniser followed by a debounce timer of width clog2(DB_CYCLES).
  - While the synchronised value equals the stable level, the timer is held at 0.
  - While the two differ, the timer increments each cycle.
  - On the edge where the timer equals DB_CYCLES-1 and the values still differ, the stable level takes the synchronised value and the timer returns to 0.
  - If the synchronised value returns to the stable level before that, the timer resets and no change is accepted.
- Latency:
  - A clean step on sw_in appears on debounced exactly DB_CYCLES+2 rising edges later.
  - Glitches shorter than DB_CYCLES cycles after synchronisation are rejected.
- Counting edge: the edge on which debounced goes 0->1.
  - On that edge, event_pulse is registered high for exactly one cycle and the count updates.
  - count and debounced change on the same edge.
- Arithmetic, up direction:
  - count+1.
  - At 2^CNT_W-1: wraps to 0 with SATURATE=0, or holds with SATURATE=1. Either way overflow is set.
- Arithmetic, down direction:
  - count-1.
  - At 0: wraps to 2^CNT_W-1 with SATURATE=0, or holds at 0 with SATURATE=1. Either way overflow is set.
- clear has priority over a simultaneous event.
  - On that edge, count goes to 0 and overflow to 0.
  - event_pulse still fires, because it reflects the debounce result, not the count.
- Channels are fully independent; simultaneous events on any subset are all counted.
- Reset asserted mid-debounce or mid-count: immediate return to reset values, with no pulse generated on release.
- At reset release with sw_in already high: after DB_CYCLES+2 edges, debounced rises and the event is counted.

Optional Feature:
COUNT_BOTH_EDGES_EN
- Defined: both 0->1 and 1->0 transitions of debounced are counting edges, each producing an event_pulse and a count update.
- Undefined: only 0->1 transitions count; 1->0 updates debounced with no pulse and no count change.

Decomposition:
- Shared package event_counter_pkg holds:
  - debounce timer width function (clog2 helper)
  - default DB_CYCLES for hardware (100000) and for simulation (4)
  - count-bus slice index helper
- One natural sub-module: debounce_channel, containing the synchroniser, debounce timer, stable level and edge pulse.
  - Instantiated NUM_CH times via generate.
  - The counter and saturate logic stay in the top.

Test Plan:
(All scenarios use NUM_CH=4, CNT_W=8, DB_CYCLES=4.)
- Reset: hold reset_n=0 with sw_in=4'hF -> all outputs 0. Release -> debounced=4'hF after 6 edges, count_bus=32'h01010101, four single-cycle pulses.
- Bounce rejection: toggle sw_in[0] high 3 cycles, low 1, high 2, low -> debounced[0] stays 0, count unchanged. A steady high of 7 cycles -> count[0]=1.
- Wrap vs saturate, dir[1]=1:
  - SATURATE=0: preload 255 via 255 presses -> next press gives 0 and overflow[1]=1.
  - SATURATE=1: count holds at 255, overflow[1]=1.
- Down count: dir[2]=0, count 0 -> press gives 255 (SATURATE=0) or 0 (SATURATE=1), overflow[2]=1. Then clear[2] -> count 0, overflow 0.
- Clear vs event: assert clear[3] on the exact edge debounced[3] rises -> count[3]=0, event_pulse[3]=1 for one cycle.
- COUNT_BOTH_EDGES_EN: one full press/release of sw_in[0] -> count[0]=2 (macro defined) vs 1 (undefined). Reset pulse mid-debounce -> no count.
